// File: rtl/ad_ip_jesd204_tpl_dac_stream_pkg.sv
// Shared definitions for the JESD204 TPL DAC stream data path.
//  - dac_sel_e   : per-channel source select encoding
//  - dac_state_e : start/sync state machine encoding
//  - dma_cdw/dac_cdw : per-channel data widths on the DMA and converter sides
//  - sat_inc16   : saturating 16-bit increment used by the underflow counter
package ad_ip_jesd204_tpl_dac_stream_pkg;

  typedef enum logic [1:0] {
    SEL_DMA      = 2'd0,
    SEL_PATTERN  = 2'd1,
    SEL_ZERO     = 2'd2,
    SEL_ZERO_ALT = 2'd3
  } dac_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2
  } dac_state_e;

  localparam int PAT_W    = 16;
  localparam int UF_CNT_W = 16;

  // Channel data width on the DMA side (containers of N' bits).
  function automatic int dma_cdw(input int dpw, input int bits_per_sample);
    return dpw * bits_per_sample;
  endfunction

  // Channel data width on the converter side (N bits per sample).
  function automatic int dac_cdw(input int dpw, input int resolution);
    return dpw * resolution;
  endfunction

  function automatic logic [UF_CNT_W-1:0] sat_inc16(input logic [UF_CNT_W-1:0] v);
    return (v == {UF_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_framer.sv
// Transport-layer framer: maps converter samples onto JESD204 lanes.
// Ports:
//  dac_data_i  : channel c sample j at [(c*DATA_PATH_WIDTH+j)*CONVERTER_RESOLUTION +: N]
//  link_data_o : lane l at [l*OCTETS_PER_BEAT*8 +: OCTETS_PER_BEAT*8]
// Mapping: each frame holds S samples of every channel, channel 0 in the least
// significant bits. A frame is split evenly across lanes, lane 0 taking the low
// part; within a lane, frame 0 occupies the low bits of the beat. Each N-bit
// sample sits MSB-aligned in its N' container with zero tail bits.
module ad_ip_jesd204_tpl_dac_framer #(
  parameter int NUM_LANES            = 1,
  parameter int NUM_CHANNELS         = 1,
  parameter int BITS_PER_SAMPLE      = 16,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int SAMPLES_PER_FRAME    = 1,
  parameter int OCTETS_PER_BEAT      = 4,
  parameter int DATA_PATH_WIDTH      = 2
) (
  input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dac_data_i,
  output logic [NUM_LANES*OCTETS_PER_BEAT*8-1:0]                       link_data_o
);

  localparam int LANE_W       = OCTETS_PER_BEAT * 8;
  localparam int FRAME_W      = NUM_CHANNELS * SAMPLES_PER_FRAME * BITS_PER_SAMPLE;
  localparam int LANE_FRAME_W = FRAME_W / NUM_LANES;
  localparam int TAIL         = BITS_PER_SAMPLE - CONVERTER_RESOLUTION;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    for (genvar j = 0; j < DATA_PATH_WIDTH; j++) begin : g_smp
      for (genvar q = 0; q < BITS_PER_SAMPLE; q++) begin : g_bit
        localparam int F   = j / SAMPLES_PER_FRAME;
        localparam int SI  = j % SAMPLES_PER_FRAME;
        localparam int G   = (c * SAMPLES_PER_FRAME + SI) * BITS_PER_SAMPLE + q;
        localparam int POS = (G / LANE_FRAME_W) * LANE_W + F * LANE_FRAME_W + (G % LANE_FRAME_W);
        if (q >= TAIL) begin : g_data
          assign link_data_o[POS] = dac_data_i[(c*DATA_PATH_WIDTH+j)*CONVERTER_RESOLUTION + q - TAIL];
        end else begin : g_tail
          assign link_data_o[POS] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_stream_skid.sv
// 2-entry valid/ready buffer between the DMA and the DAC sample path.
// Ports:
//  clk, reset     : link clock, synchronous active-high reset (clears fill level)
//  flush_i        : empties the buffer; a push in the same cycle is dropped too
//  in_valid_i/in_ready_o/in_data_i : upstream handshake (ready low during reset)
//  out_valid_o/out_data_o          : head entry
//  pop_i          : consume head entry; ignored when empty
module ad_ip_jesd204_tpl_dac_skid #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              pop_i
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic              push, pop;

  assign in_ready_o  = !reset && (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = e0_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = pop_i && out_valid_o;

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = in_data_i;
        else               e1_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Fill level is unchanged; the new beat lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          e0_d = in_data_i;
        end else begin
          e0_d = e1_q;
          e1_d = in_data_i;
        end
      end
      default: ;
    endcase
    if (flush_i) cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 2'd0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_stream.sv
// JESD204 transport-layer DAC data path: DMA skid buffer, sync/start FSM,
// per-channel source select, underflow detection and lane framing.
// Ports:
//  clk, reset                         : link clock, synchronous active-high reset
//  link_valid/link_ready/link_data    : beat interface to the link layer TX
//  dma_valid/dma_ready/dma_data       : DMA beat interface (all channels at once)
//  enable, dac_data_sel               : per-channel enable and source select
//  dac_pat_data_0/1                   : per-channel pattern words (even/odd samples)
//  dac_sync, dac_external_sync        : arm/start pulse and external start level
//  dac_sync_armed, dac_running        : FSM status
//  dac_underflow, underflow_clr, underflow_count : underflow pulse and counter
module ad_ip_jesd204_tpl_dac_stream
  import ad_ip_jesd204_tpl_dac_stream_pkg::*;
#(
  parameter int NUM_LANES            = 1,
  parameter int NUM_CHANNELS         = 1,
  parameter int BITS_PER_SAMPLE      = 16,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int SAMPLES_PER_FRAME    = 1,
  parameter int OCTETS_PER_BEAT      = 4,
  // Samples per channel per beat must fill the link exactly.
  parameter int DATA_PATH_WIDTH      = OCTETS_PER_BEAT * 8 * NUM_LANES / (NUM_CHANNELS * BITS_PER_SAMPLE),
  parameter int LINK_DATA_WIDTH      = NUM_LANES * OCTETS_PER_BEAT * 8,
  parameter int DMA_DATA_WIDTH       = DATA_PATH_WIDTH * BITS_PER_SAMPLE * NUM_CHANNELS,
  parameter bit EXT_SYNC             = 1'b1,
  parameter bit UNDERFLOW_HOLD       = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         link_valid,
  input  logic                         link_ready,
  output logic [LINK_DATA_WIDTH-1:0]   link_data,
  input  logic                         dma_valid,
  output logic                         dma_ready,
  input  logic [DMA_DATA_WIDTH-1:0]    dma_data,
  input  logic [NUM_CHANNELS-1:0]      enable,
  input  logic [NUM_CHANNELS*2-1:0]    dac_data_sel,
  input  logic [NUM_CHANNELS*PAT_W-1:0] dac_pat_data_0,
  input  logic [NUM_CHANNELS*PAT_W-1:0] dac_pat_data_1,
  input  logic                         dac_sync,
  input  logic                         dac_external_sync,
  output logic                         dac_sync_armed,
  output logic                         dac_running,
  output logic                         dac_underflow,
  input  logic                         underflow_clr,
  output logic [UF_CNT_W-1:0]          underflow_count
);

  localparam int DMA_CDW = dma_cdw(DATA_PATH_WIDTH, BITS_PER_SAMPLE);
  localparam int DAC_CDW = dac_cdw(DATA_PATH_WIDTH, CONVERTER_RESOLUTION);

  dac_state_e                    state_q;
  logic                          armed_q, running_q;
  logic                          link_valid_q, underflow_q;
  logic [UF_CNT_W-1:0]           uf_count_q, uf_count_d;
  logic [LINK_DATA_WIDTH-1:0]    link_data_q;
  logic [DMA_DATA_WIDTH-1:0]     last_beat_q;

  logic                          xfer, dma_wanted, pop, underflow, flush;
  logic                          skid_valid;
  logic [DMA_DATA_WIDTH-1:0]     skid_data, dma_beat;
  logic [NUM_CHANNELS*DAC_CDW-1:0] dac_data;
  logic [LINK_DATA_WIDTH-1:0]    framed;

  // MSB-aligned truncation of a DMA container to converter resolution.
  function automatic logic [CONVERTER_RESOLUTION-1:0] trunc_dma(input logic [BITS_PER_SAMPLE-1:0] v);
    return v[BITS_PER_SAMPLE-1 -: CONVERTER_RESOLUTION];
  endfunction

  function automatic logic [CONVERTER_RESOLUTION-1:0] trunc_pat(input logic [PAT_W-1:0] v);
    return v[PAT_W-1 -: CONVERTER_RESOLUTION];
  endfunction

  assign xfer = link_valid_q && link_ready;

  always_comb begin
    dma_wanted = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (enable[c] && (dac_data_sel[2*c +: 2] == SEL_DMA)) dma_wanted = 1'b1;
    end
  end

  assign pop       = xfer && running_q && dma_wanted;
  assign underflow = pop && !skid_valid;
  // A re-sync while running without external sync restarts the DMA stream.
  assign flush     = running_q && dac_sync && !EXT_SYNC;

  ad_ip_jesd204_tpl_dac_skid #(
    .DATA_W (DMA_DATA_WIDTH)
  ) i_skid (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_valid_i  (dma_valid),
    .in_ready_o  (dma_ready),
    .in_data_i   (dma_data),
    .out_valid_o (skid_valid),
    .out_data_o  (skid_data),
    .pop_i       (pop)
  );

  // Source select; only meaningful on cycles that transfer, since link_data holds otherwise.
  always_comb begin
    dma_beat = skid_valid ? skid_data : (UNDERFLOW_HOLD ? last_beat_q : '0);
    dac_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int j = 0; j < DATA_PATH_WIDTH; j++) begin
        if (running_q && enable[c]) begin
          unique case (dac_sel_e'(dac_data_sel[2*c +: 2]))
            SEL_DMA:
              dac_data[c*DAC_CDW + j*CONVERTER_RESOLUTION +: CONVERTER_RESOLUTION] =
                trunc_dma(dma_beat[c*DMA_CDW + j*BITS_PER_SAMPLE +: BITS_PER_SAMPLE]);
            SEL_PATTERN:
              dac_data[c*DAC_CDW + j*CONVERTER_RESOLUTION +: CONVERTER_RESOLUTION] =
                trunc_pat((j % 2 == 0) ? dac_pat_data_0[c*PAT_W +: PAT_W]
                                       : dac_pat_data_1[c*PAT_W +: PAT_W]);
            default: ;
          endcase
        end
      end
    end
  end

  ad_ip_jesd204_tpl_dac_framer #(
    .NUM_LANES            (NUM_LANES),
    .NUM_CHANNELS         (NUM_CHANNELS),
    .BITS_PER_SAMPLE      (BITS_PER_SAMPLE),
    .CONVERTER_RESOLUTION (CONVERTER_RESOLUTION),
    .SAMPLES_PER_FRAME    (SAMPLES_PER_FRAME),
    .OCTETS_PER_BEAT      (OCTETS_PER_BEAT),
    .DATA_PATH_WIDTH      (DATA_PATH_WIDTH)
  ) i_framer (
    .dac_data_i  (dac_data),
    .link_data_o (framed)
  );

  assign uf_count_d = underflow_clr ? '0 : (underflow ? sat_inc16(uf_count_q) : uf_count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      underflow_q  <= 1'b0;
      uf_count_q   <= '0;
      last_beat_q  <= '0;
    end else begin
      link_valid_q <= 1'b1;
      if (xfer) link_data_q <= framed;
      if (pop && skid_valid) last_beat_q <= skid_data;
      underflow_q  <= underflow;
      uf_count_q   <= uf_count_d;
    end
  end

  // Start FSM. A dac_sync while ARMED keeps it armed even if the external
  // sync is high in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (dac_sync) begin
            state_q   <= EXT_SYNC ? ST_ARMED : ST_RUNNING;
            armed_q   <= EXT_SYNC;
            running_q <= !EXT_SYNC;
          end
        end
        ST_ARMED: begin
          if (!dac_sync && dac_external_sync) begin
            state_q   <= ST_RUNNING;
            armed_q   <= 1'b0;
            running_q <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (dac_sync && EXT_SYNC) begin
            state_q   <= ST_ARMED;
            armed_q   <= 1'b1;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          armed_q   <= 1'b0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign link_valid      = link_valid_q;
  assign link_data       = link_data_q;
  assign dac_sync_armed  = armed_q;
  assign dac_running     = running_q;
  assign dac_underflow   = underflow_q;
  assign underflow_count = uf_count_q;

endmodule
